alu_packet_ctrl: RTL and testbench

Packet controller between the UART core's AXI-stream byte interfaces and the arithmetic unit. It parses framed command packets arriving from UART RX and sequences the external ALU across a variable-length operand list with a start/done handshake. It returns results, or echoed payload, byte-serially to UART TX. It is instantiated inside `top` between the `uart` instance and the ALU.

---
 rtl/alu_packet_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_packet_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_packet_ctrl.sv
// Packet controller between the UART byte streams and the external ALU.
// Parses framed commands, sequences the ALU over an operand list and returns results or echo data.
module alu_packet_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [1:0]            alu_op_o,
    output logic [31:0]           alu_a_o,
    output logic [31:0]           alu_b_o,
    output logic                  alu_start_o,
    input  logic                  alu_done_i,
    input  logic [31:0]           alu_result_i,
    output logic                  err_o
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LEN_W  = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HDR   = 3'd1;
    localparam logic [2:0] ST_ECHO  = 3'd2;
    localparam logic [2:0] ST_OPER  = 3'd3;
    localparam logic [2:0] ST_EXEC  = 3'd4;
    localparam logic [2:0] ST_SEND  = 3'd5;
    localparam logic [2:0] ST_DRAIN = 3'd6;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hA0;
    localparam logic [7:0] OP_MUL  = 8'hA1;
    localparam logic [7:0] OP_DIV  = 8'hA2;

    logic [2:0]        state_q, state_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [1:0]        hdr_cnt_q, hdr_cnt_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] opnd_q, opnd_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic              first_q, first_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              start_q, start_d;
    logic [WORD_W-1:0] a_q, a_d;
    logic [WORD_W-1:0] b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic              err_q, err_d;

    logic              rx_ready;
    logic              rx_fire;
    logic              is_arith;
    logic [LEN_W-1:0]  len_w;
    logic [LEN_W-1:0]  rem_w;
    logic [WORD_W-1:0] word_w;

    // Echo is a combinational pass-through; every other state drives TX from registers.
    assign rx_ready      = (state_q == ST_IDLE) || (state_q == ST_HDR) ||
                           (state_q == ST_OPER) || (state_q == ST_DRAIN);
    assign s_axis_tready = (state_q == ST_ECHO) ? m_axis_tready : rx_ready;
    assign m_axis_tvalid = (state_q == ST_ECHO) ? s_axis_tvalid : tx_valid_q;
    assign m_axis_tdata  = (state_q == ST_ECHO) ? s_axis_tdata  : tx_data_q;
    assign rx_fire       = s_axis_tvalid && s_axis_tready;

    assign is_arith = (opcode_q == OP_ADD) || (opcode_q == OP_MUL) || (opcode_q == OP_DIV);
    assign len_w    = {s_axis_tdata, len_lo_q};
    assign rem_w    = len_w - LEN_W'(4);
    assign word_w   = {s_axis_tdata, opnd_q[WORD_W-1:8]};

    assign alu_start_o = start_q;
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign alu_op_o    = op_q;
    assign err_o       = err_q;

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        hdr_cnt_d  = hdr_cnt_q;
        len_lo_d   = len_lo_q;
        remain_d   = remain_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        byte_cnt_d = byte_cnt_q;
        first_d    = first_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        start_d    = 1'b0;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_fire) begin
                    opcode_d  = s_axis_tdata;
                    hdr_cnt_d = 2'd0;
                    state_d   = ST_HDR;
                end
            end
            ST_HDR: begin
                if (rx_fire) begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd1) begin
                        len_lo_d = s_axis_tdata;
                    end
                    if (hdr_cnt_q == 2'd2) begin
                        remain_d   = rem_w;
                        byte_cnt_d = 2'd0;
                        first_d    = 1'b1;
                        if (len_w < LEN_W'(4)) begin
                            err_d    = 1'b1;
                            remain_d = '0;
                            state_d  = ST_IDLE;
                        end else if (opcode_q == OP_ECHO) begin
                            state_d = (rem_w == '0) ? ST_IDLE : ST_ECHO;
                        end else if (!is_arith || (rem_w[1:0] != 2'b00) || (rem_w < LEN_W'(8)) ||
                                     ((opcode_q == OP_DIV) && (rem_w != LEN_W'(8)))) begin
                            err_d   = 1'b1;
                            state_d = (rem_w == '0) ? ST_IDLE : ST_DRAIN;
                        end else begin
                            state_d = ST_OPER;
                        end
                    end
                end
            end
            ST_ECHO, ST_DRAIN: begin
                if (rx_fire) begin
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_OPER: begin
                // Operands arrive LSB first, so shift each byte in from the top.
                if (rx_fire) begin
                    remain_d   = remain_q - LEN_W'(1);
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    opnd_d     = word_w;
                    if (byte_cnt_q == 2'd3) begin
                        if (first_q) begin
                            acc_d   = word_w;
                            first_d = 1'b0;
                        end else begin
                            a_d     = acc_q;
                            b_d     = word_w;
                            op_d    = opcode_q[1:0];
                            start_d = 1'b1;
                            state_d = ST_EXEC;
                        end
                    end
                end
            end
            ST_EXEC: begin
                if (alu_done_i) begin
                    acc_d = alu_result_i;
                    if (remain_q == '0) begin
                        byte_cnt_d = 2'd0;
                        tx_valid_d = 1'b1;
                        tx_data_d  = alu_result_i[7:0];
                        state_d    = ST_SEND;
                    end else begin
                        state_d = ST_OPER;
                    end
                end
            end
            ST_SEND: begin
                if (m_axis_tready) begin
                    if (byte_cnt_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        tx_data_d  = acc_q[{byte_cnt_d, 3'b000} +: 8];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            opcode_q   <= '0;
            hdr_cnt_q  <= '0;
            len_lo_q   <= '0;
            remain_q   <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            byte_cnt_q <= '0;
            first_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            start_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            hdr_cnt_q  <= hdr_cnt_d;
            len_lo_q   <= len_lo_d;
            remain_q   <= remain_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            byte_cnt_q <= byte_cnt_d;
            first_q    <= first_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            start_q    <= start_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_packet_ctrl.sv
// Bench for alu_packet_ctrl: directed vector table, reset-mid-send sequence and
// randomized packets scored against a packet-level reference model.
module tb_alu_packet_ctrl;

    typedef logic [7:0] byte_q_t[$];

    typedef struct packed {
        logic [159:0] pkt;
        int unsigned  plen;
        logic [63:0]  tx;
        int unsigned  tlen;
        int unsigned  errs;
        int unsigned  starts;
        int unsigned  txmode;
        int unsigned  dly;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [1:0]  alu_op_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic        alu_start_o;
    logic        alu_done_i;
    logic [31:0] alu_result_i;
    logic        err_o;

    int unsigned checks;
    int unsigned errors;
    int unsigned err_cnt;
    int unsigned start_cnt;
    int unsigned tx_mode;
    int unsigned alu_dly;
    bit          rx_gaps;
    bit          arith_pkt;
    byte_q_t     txq;
    vec_t        vecs[12];

    alu_packet_ctrl #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .alu_op_o     (alu_op_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_start_o  (alu_start_o),
        .alu_done_i   (alu_done_i),
        .alu_result_i (alu_result_i),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ALU semantics assumed for the external unit: wrap add/mul, signed div, all-ones on /0.
    function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        case (op)
            2'd0: return a + b;
            2'd1: begin prod = {32'd0, a} * {32'd0, b}; return prod[31:0]; end
            default: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'($signed(a) / $signed(b));
            end
        endcase
    endfunction

    // Packet-level reference: what a whole packet should produce on TX, err_o and alu_start_o.
    function automatic void ref_model(input byte_q_t p, output byte_q_t tx,
                                      output int unsigned errs, output int unsigned starts);
        int          len;
        int          rem;
        logic [31:0] acc;
        logic [31:0] w;
        tx = {};
        errs = 0;
        starts = 0;
        len = int'({p[3], p[2]});
        rem = len - 4;
        if (len < 4) begin
            errs = 1;
            return;
        end
        if (p[0] == 8'hEC) begin
            for (int i = 4; i < len; i++) tx.push_back(p[i]);
        end else if (p[0] == 8'hA0 || p[0] == 8'hA1 || p[0] == 8'hA2) begin
            if ((rem % 4) != 0 || rem < 8 || (p[0] == 8'hA2 && rem != 8)) begin
                errs = 1;
            end else begin
                acc = {p[7], p[6], p[5], p[4]};
                for (int k = 1; k < rem / 4; k++) begin
                    w = {p[4*k+7], p[4*k+6], p[4*k+5], p[4*k+4]};
                    acc = alu_ref(p[0][1:0], acc, w);
                    starts++;
                end
                for (int i = 0; i < 4; i++) tx.push_back(acc[8*i +: 8]);
            end
        end else begin
            errs = 1;
        end
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        bit f;
        n = 0;
        f = 1'b0;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        while (!f && n < 3000) begin
            @(negedge clk);
            f = s_axis_tready;
            @(posedge clk); #1;
            n++;
        end
        if (!f) chk("rx_accept_timeout", 32'(f), 32'd1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic apply(input string tag, input byte_q_t p, input byte_q_t etx,
                         input int unsigned eerr, input int unsigned est);
        int unsigned e0;
        int unsigned s0;
        int          n;
        e0 = err_cnt;
        s0 = start_cnt;
        txq.delete();
        arith_pkt = (p[0] == 8'hA0 || p[0] == 8'hA1 || p[0] == 8'hA2);
        foreach (p[i]) begin
            send_byte(p[i]);
            if (rx_gaps) cyc($urandom_range(0, 2));
        end
        n = 0;
        while (txq.size() < etx.size() && n < 5000) begin cyc(1); n++; end
        chk({tag, "_tx_timeout"}, 32'(n < 5000), 32'd1);
        cyc(30);
        chk({tag, "_txlen"}, 32'(txq.size()), 32'(etx.size()));
        for (int i = 0; i < etx.size() && i < txq.size(); i++)
            chk({tag, "_txbyte"}, 32'(txq[i]), 32'(etx[i]));
        chk({tag, "_err_pulses"}, err_cnt - e0, eerr);
        chk({tag, "_alu_starts"}, start_cnt - s0, est);
        chk({tag, "_idle_rx_ready"}, 32'(s_axis_tready), 32'd1);
        chk({tag, "_idle_tx_valid"}, 32'(m_axis_tvalid), 32'd0);
        arith_pkt = 1'b0;
    endtask

    // TX sink: always-ready, random, or five stall cycles per byte.
    initial begin : tx_sink
        int wcnt;
        wcnt = 0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (tx_mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = 1'($urandom_range(0, 1));
                default: begin
                    if (!m_axis_tvalid) begin
                        m_axis_tready = 1'b0;
                        wcnt = 0;
                    end else if (wcnt < 5) begin
                        m_axis_tready = 1'b0;
                        wcnt++;
                    end else begin
                        m_axis_tready = 1'b1;
                        wcnt = 0;
                    end
                end
            endcase
        end
    end

    // External ALU stand-in; also watches that EXEC holds RX off and keeps operands stable.
    initial begin : alu_stub
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        alu_done_i   = 1'b0;
        alu_result_i = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (rst && alu_start_o) begin
                a = alu_a_o;
                b = alu_b_o;
                op = alu_op_o;
                for (int i = 0; i < int'(alu_dly); i++) begin
                    chk("exec_rx_blocked", 32'(s_axis_tready), 32'd0);
                    @(posedge clk); #1;
                    chk("exec_alu_a_hold", alu_a_o, a);
                    chk("exec_alu_b_hold", alu_b_o, b);
                    chk("exec_alu_op_hold", 32'(alu_op_o), 32'(op));
                end
                alu_result_i = alu_ref(op, a, b);
                alu_done_i   = 1'b1;
                @(posedge clk); #1;
                alu_done_i   = 1'b0;
            end
        end
    end

    // Output monitor sampled mid-cycle.
    bit         stall_q;
    logic [7:0] stall_d;
    always @(negedge clk) begin
        if (rst) begin
            if (err_o) err_cnt++;
            if (alu_start_o) start_cnt++;
            if (m_axis_tvalid && m_axis_tready) txq.push_back(m_axis_tdata);
            if (stall_q && m_axis_tvalid) chk("tx_data_hold", 32'(m_axis_tdata), 32'(stall_d));
            if (arith_pkt && m_axis_tvalid) chk("send_rx_blocked", 32'(s_axis_tready), 32'd0);
            stall_q = m_axis_tvalid && !m_axis_tready;
            stall_d = m_axis_tdata;
        end else begin
            stall_q = 1'b0;
        end
    end

    initial begin : main
        byte_q_t     p;
        byte_q_t     etx;
        int unsigned ee;
        int unsigned es;
        int          n;
        int          kind;
        logic [7:0]  op;
        logic [15:0] len;
        logic [31:0] v;

        checks = 0; errors = 0; err_cnt = 0; start_cnt = 0;
        tx_mode = 0; alu_dly = 0; rx_gaps = 1'b0; arith_pkt = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = 8'd0;
        rst = 1'b1;
        #2 rst = 1'b0;
        cyc(3);
        chk("rst_s_tready", 32'(s_axis_tready), 32'd1);
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_alu_start", 32'(alu_start_o), 32'd0);
        chk("rst_alu_a", alu_a_o, 32'd0);
        chk("rst_alu_b", alu_b_o, 32'd0);
        chk("rst_alu_op", 32'(alu_op_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst = 1'b1;
        cyc(2);

        // pkt / tx are byte 0 at the LSB; fields: pkt, plen, tx, tlen, errs, starts, txmode, dly
        vecs[0]  = '{160'h434241_000700EC, 7, 64'h434241, 3, 0, 0, 0, 0};
        vecs[1]  = '{160'h00000003_00000002_00000001_001000A0, 16, 64'h00000006, 4, 0, 2, 0, 0};
        vecs[2]  = '{160'h00000002_FFFFFFFF_000C00A1, 12, 64'hFFFFFFFE, 4, 0, 1, 2, 1};
        vecs[3]  = '{160'h00000003_00000002_00000001_001000A2, 16, 64'h0, 0, 1, 0, 0, 0};
        vecs[4]  = '{160'h77_00050055, 5, 64'h0, 0, 1, 0, 0, 0};
        vecs[5]  = '{160'h00000020_00000010_000C00A0, 12, 64'h00000030, 4, 0, 1, 0, 0};
        vecs[6]  = '{160'h0000000A_00000014_00000005_001000A0, 16, 64'h00000023, 4, 0, 2, 1, 20};
        vecs[7]  = '{160'h00000002_FFFFFFF9_000C00A2, 12, 64'hFFFFFFFD, 4, 0, 1, 0, 2};
        vecs[8]  = '{160'h000200EC, 4, 64'h0, 0, 1, 0, 0, 0};
        vecs[9]  = '{160'h000400EC, 4, 64'h0, 0, 0, 0, 0, 0};
        vecs[10] = '{160'h00000005_000800A0, 8, 64'h0, 0, 1, 0, 0, 0};
        vecs[11] = '{160'h00000007_00000064_000C00A2, 12, 64'h0000000E, 4, 0, 1, 1, 0};

        foreach (vecs[k]) begin
            p = {};
            etx = {};
            for (int i = 0; i < int'(vecs[k].plen); i++) p.push_back(vecs[k].pkt[8*i +: 8]);
            for (int i = 0; i < int'(vecs[k].tlen); i++) etx.push_back(vecs[k].tx[8*i +: 8]);
            tx_mode = vecs[k].txmode;
            alu_dly = vecs[k].dly;
            apply($sformatf("vec%0d", k), p, etx, vecs[k].errs, vecs[k].starts);
        end

        // Reset while the third result byte is stalled on TX.
        tx_mode = 2; alu_dly = 0; rx_gaps = 1'b0;
        txq.delete();
        arith_pkt = 1'b1;
        p = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        foreach (p[i]) send_byte(p[i]);
        n = 0;
        while (txq.size() < 2 && n < 2000) begin cyc(1); n++; end
        chk("rst_send_reach", 32'(n < 2000), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_send_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_send_m_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_send_s_tready", 32'(s_axis_tready), 32'd1);
        cyc(3);
        chk("rst_hold_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        rst = 1'b1;
        arith_pkt = 1'b0;
        cyc(20);
        chk("rst_send_txlen", 32'(txq.size()), 32'd2);
        if (txq.size() >= 2) begin
            chk("rst_send_b0", 32'(txq[0]), 32'h03);
            chk("rst_send_b1", 32'(txq[1]), 32'h00);
        end
        tx_mode = 0;
        p = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h5A, 8'hA5};
        etx = '{8'h5A, 8'hA5};
        apply("post_rst_echo", p, etx, 0, 0);

        // Randomized packets against the reference model.
        for (int t = 0; t < 40; t++) begin
            p = {};
            kind = $urandom_range(0, 4);
            n = 0;
            case (kind)
                0: begin op = 8'hEC; n = $urandom_range(0, 8); end
                1: begin op = 8'hA0 + 8'($urandom_range(0, 1)); n = 4 * $urandom_range(2, 4); end
                2: begin op = 8'hA2; n = 8; end
                3: begin
                    op = 8'($urandom);
                    while (op == 8'hEC || op == 8'hA0 || op == 8'hA1 || op == 8'hA2) op = 8'($urandom);
                    n = $urandom_range(0, 5);
                end
                default: begin
                    op = 8'hA0 + 8'($urandom_range(0, 2));
                    case ($urandom_range(0, 3))
                        0: n = 0;
                        1: n = 4;
                        2: n = 6;
                        default: n = (op == 8'hA2) ? 12 : 9;
                    endcase
                end
            endcase
            len = 16'(n + 4);
            p.push_back(op);
            p.push_back(8'($urandom));
            p.push_back(len[7:0]);
            p.push_back(len[15:8]);
            if (kind == 1 || kind == 2) begin
                for (int w = 0; w < n / 4; w++) begin
                    v = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 300));
                    if (kind == 2 && w == 1) v = 32'($signed($urandom_range(0, 20)) - 10);
                    for (int i = 0; i < 4; i++) p.push_back(v[8*i +: 8]);
                end
            end else begin
                for (int i = 0; i < n; i++) p.push_back(8'($urandom));
            end
            tx_mode = $urandom_range(0, 1);
            alu_dly = $urandom_range(0, 3);
            rx_gaps = 1'($urandom_range(0, 1));
            ref_model(p, etx, ee, es);
            apply($sformatf("rand%0d", t), p, etx, ee, es);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
